// File: rtl/muldiv_writeback_unit.sv
// Iterative 64-bit multiply/divide unit that stalls the pipeline and issues one register write per operation.
// Define MULDIV_DIV_EN to build the divider; without it UDIV/SDIV complete in one cycle with a zero result.
module muldiv_writeback_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       Rd,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic             WrEn,
    output logic [4:0]       WrReg,
    output logic [WIDTH-1:0] WrData
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [1:0]         op;
    logic [4:0]         rd;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;   // multiplicand or divisor
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   result;
    logic               skip;

    assign Stall = Busy | (Start & (state == IDLE));

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic               neg;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Restoring step: shifted remainder minus divisor; a borrow means keep the shifted remainder.
    assign div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    assign div_next  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign step_next = op[1] ? div_next : mul_next;
    assign a_mag     = (Op[0] && OpA[WIDTH-1]) ? -OpA : OpA;
    assign b_mag     = (Op[0] && OpB[WIDTH-1]) ? -OpB : OpB;
    assign skip      = Op[1] && (OpB == '0);

    always_comb begin
        result = acc[WIDTH-1:0];
        case (op)
            2'b01:   result = acc[2*WIDTH-1:WIDTH];
            2'b11:   result = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            default: result = acc[WIDTH-1:0];
        endcase
    end
`else
    assign step_next = mul_next;
    assign skip      = Op[1];

    always_comb begin
        result = '0;
        case (op)
            2'b00:   result = acc[WIDTH-1:0];
            2'b01:   result = acc[2*WIDTH-1:WIDTH];
            default: result = '0;
        endcase
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state  <= IDLE;
            op     <= '0;
            rd     <= '0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            WrEn   <= 1'b0;
            WrReg  <= '0;
            WrData <= '0;
`ifdef MULDIV_DIV_EN
            neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op   <= Op;
                        rd   <= Rd;
                        Busy <= 1'b1;
                        cnt  <= CNT_W'(WIDTH);
`ifdef MULDIV_DIV_EN
                        neg  <= Op[0] & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
`endif
                        if (skip) begin
                            acc   <= '0;
                            state <= DONE;
`ifdef MULDIV_DIV_EN
                        end else if (Op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opb   <= b_mag;
                            state <= CALC;
`endif
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, OpB};
                            opb   <= OpA;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    // First DONE cycle settles the result; second presents the write pulse.
                    if (!Done) begin
                        Done   <= 1'b1;
                        WrEn   <= (rd != 5'd31);
                        WrReg  <= rd;
                        WrData <= result;
                    end else begin
                        Done   <= 1'b0;
                        WrEn   <= 1'b0;
                        WrReg  <= '0;
                        WrData <= '0;
                        Busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// Scoreboard bench for muldiv_writeback_unit: directed operations queue expected writes, a monitor checks each Done.
module tb_muldiv_writeback_unit;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = '0;
    logic [63:0] OpA = '0;
    logic [63:0] OpB = '0;
    logic [4:0]  Rd = '0;
    logic        Stall, Busy, Done, WrEn;
    logic [4:0]  WrReg;
    logic [63:0] WrData;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wren;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

`ifdef MULDIV_DIV_EN
    localparam int DLAT = 65;
    localparam bit DIVON = 1'b1;
`else
    localparam int DLAT = 1;
    localparam bit DIVON = 1'b0;
`endif

    muldiv_writeback_unit #(.WIDTH(64), .CNT_W(7)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB), .Rd(Rd),
        .Stall(Stall), .Busy(Busy), .Done(Done), .WrEn(WrEn), .WrReg(WrReg), .WrData(WrData)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: WrReg=%0d WrData=0x%0h with nothing expected", WrReg, WrData);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wrdata", WrData, e.data);
                    chk("wrreg", 64'(WrReg), 64'(e.rd));
                    chk("wren", 64'(WrEn), 64'(e.wren));
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end else if (WrEn) begin
                checks++;
                failures++;
                $display("FAIL wren_without_done: WrReg=%0d", WrReg);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: Busy still 1 after %0d cycles", n);
        end
        @(negedge Clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] exp, input int lat, input bit want);
        exp_t e;
        @(negedge Clk);
        Start = 1'b1; Op = op; OpA = a; OpB = b; Rd = rd;
        if (want) begin
            e.data = exp; e.rd = rd; e.wren = (rd != 5'd31); e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        #1 chk("stall_on_start", 64'(Stall), 64'd1);
        @(negedge Clk);
        Start = 1'b0; OpA = ~a; OpB = ~b; Rd = ~rd;
        chk("busy_after_accept", 64'(Busy), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_wren", 64'(WrEn), 64'd0);
        chk("rst_wrdata", WrData, 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        issue(2'b00, 64'h0000_0001_0000_0003, 64'h5, 5'd4, 64'h0000_0005_0000_000F, 65, 1'b1);
        wait_idle();
        issue(2'b01, '1, '1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);
        wait_idle();
        issue(2'b00, '1, '1, 5'd6, 64'h1, 65, 1'b1);
        wait_idle();
        issue(2'b11, -64'sd7, 64'd2, 5'd7, DIVON ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0, DLAT, 1'b1);
        wait_idle();
        issue(2'b11, 64'h8000_0000_0000_0000, '1, 5'd8, DIVON ? 64'h8000_0000_0000_0000 : 64'h0, DLAT, 1'b1);
        wait_idle();
        issue(2'b10, 64'd100, 64'd7, 5'd9, DIVON ? 64'd14 : 64'd0, DLAT, 1'b1);
        wait_idle();
        issue(2'b10, 64'd5, 64'd0, 5'd10, 64'd0, 1, 1'b1);
        wait_idle();
        issue(2'b11, 64'd9, 64'd0, 5'd11, 64'd0, 1, 1'b1);
        wait_idle();

        // Start during CALC with other operands must be ignored.
        issue(2'b00, 64'd3, 64'd5, 5'd12, 64'd15, 65, 1'b1);
        repeat (9) @(negedge Clk);
        Start = 1'b1; Op = 2'b01; OpA = 64'd100; OpB = 64'd100; Rd = 5'd13;
        @(negedge Clk);
        Start = 1'b0;
        wait_idle();

        issue(2'b00, 64'd7, 64'd6, 5'd31, 64'd42, 65, 1'b1);
        wait_idle();

        // Reset mid-operation (with Start high) drops the operation entirely.
        issue(2'b00, 64'd11, 64'd13, 5'd14, 64'd0, 0, 1'b0);
        repeat (29) @(negedge Clk);
        Reset_n = 1'b0; Start = 1'b1; Op = 2'b00;
        @(negedge Clk);
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_done", 64'(Done), 64'd0);
        chk("midrst_wren", 64'(WrEn), 64'd0);
        chk("midrst_wrreg", 64'(WrReg), 64'd0);
        chk("midrst_wrdata", WrData, 64'd0);
        Start = 1'b0;
        @(negedge Clk);
        chk("midrst_stays_idle", 64'(Busy), 64'd0);
        Reset_n = 1'b1;
        repeat (70) @(negedge Clk);

        issue(2'b00, 64'd11, 64'd13, 5'd15, 64'd143, 65, 1'b1);
        wait_idle();
        repeat (3) @(negedge Clk);

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_writes: %0d expected writes never seen", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
